// File: rtl/two_bit_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : two_bit_serial_subtractor
//  Description : Digit-serial subtractor computing (A - B - Bin) mod 2^WIDTH.
//                It processes one 2-bit digit per clock, least-significant
//                digit first, and reports the final borrow as Bout. A
//                three-state controller (IDLE -> RUN -> DONE) sequences each
//                operation. done pulses for one cycle when a result is ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module two_bit_serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] diff,
    output logic             Bout,
    output logic             busy,
    output logic             done
);

    localparam int                 c_DIGITS = WIDTH / 2;
    localparam int                 c_CNT_W  = (c_DIGITS > 1) ? $clog2(c_DIGITS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST   = c_CNT_W'(c_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_result;
    logic               r_borrow;
    logic [c_CNT_W-1:0] r_cnt;

    logic [2:0]         w_digit_sub;
    logic [WIDTH-1:0]   w_result_next;

    // Subtract the current low digit pair with the running borrow. Bit 2 of
    // the 3-bit two's-complement result is the borrow into the next digit.
    // The new digit enters at the top of the result register, so after
    // WIDTH/2 shifts the first digit sits in bits [1:0].
    always_comb begin
        w_digit_sub   = {1'b0, r_a[1:0]} - {1'b0, r_b[1:0]} - {2'b00, r_borrow};
        w_result_next = (r_result >> 2) | (WIDTH'(w_digit_sub[1:0]) << (WIDTH - 2));
    end

    // Controller, operand shifters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            diff     <= '0;
            Bout     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a      <= A;
                        r_b      <= B;
                        r_borrow <= Bin;
                        r_cnt    <= '0;
                        busy     <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    // Operands shift right so the next digit is always in [1:0].
                    r_a      <= r_a >> 2;
                    r_b      <= r_b >> 2;
                    r_result <= w_result_next;
                    r_borrow <= w_digit_sub[2];
                    r_cnt    <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_LAST) begin
                        diff    <= w_result_next;
                        Bout    <= w_digit_sub[2];
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/two_bit_serial_subtractor.md
TWO_BIT_SERIAL_SUBTRACTOR -- requirements
Module: two_bit_serial_subtractor

Interface
REQ-001 The block SHALL have this parameter: WIDTH, 8, operand width in bits; legal values are even and 2 or greater.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 The block SHALL have this port: clk  input  1  clock; all state changes on its rising edge.
REQ-004 The block SHALL have this port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have this port: start  input  1  request a subtraction; sampled only in IDLE.
REQ-006 The block SHALL have this port: A  input  WIDTH  minuend; sampled on the accepting edge only.
REQ-007 The block SHALL have this port: B  input  WIDTH  subtrahend; sampled on the accepting edge only.
REQ-008 The block SHALL have this port: Bin  input  1  borrow-in; sampled on the accepting edge only.
REQ-009 The block SHALL have this port: diff  output  WIDTH  registered result, (A - B - Bin) mod 2^WIDTH.
REQ-010 The block SHALL have this port: Bout  output  1  registered borrow-out; 1 exactly when A < B + Bin (unsigned).
REQ-011 The block SHALL have this port: busy  output  1  high while state is RUN.
REQ-012 The block SHALL have this port: done  output  1  one-cycle pulse; diff and Bout are valid in this cycle.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE, a rising edge with start=1 SHALL do all of the following: latch A, B and Bin into internal registers; load the borrow register with Bin; clear the digit counter to 0; move to RUN. This edge is the accepting edge.
REQ-015 Each RUN edge SHALL process one 2-bit digit, least-significant digit first: {borrow_next, d[1:0]} = a[2k+1:2k] - b[2k+1:2k] - borrow, evaluated as a 3-bit two's-complement result.
REQ-016 Each digit d SHALL be shifted into an internal result register. The borrow register SHALL update to borrow_next. The counter SHALL increment.
REQ-017 RUN SHALL last exactly WIDTH/2 edges. On the edge that processes digit WIDTH/2-1, the block SHALL load diff from the completed result register, load Bout from the final borrow, and move to DONE.
REQ-018 DONE SHALL last exactly one cycle. done=1 in DONE and 0 in every other state. The next edge SHALL return the FSM to IDLE unconditionally.
REQ-019 Latency: done SHALL be high in the cycle after the (WIDTH/2)th edge that follows the accepting edge. This is 4 edges for WIDTH=8. Accepting-edge to accepting-edge spacing is at least WIDTH/2+2 edges.
REQ-020 busy SHALL be 1 exactly in RUN.
REQ-021 diff and Bout SHALL hold their previous values in IDLE, in RUN and between operations. They SHALL change only on the edge that enters DONE.
REQ-022 start SHALL be ignored in RUN and in DONE. It SHALL have no effect on operands, counter or outputs.
REQ-023 Changes on A, B or Bin after the accepting edge SHALL NOT affect the result.
REQ-024 If start is held high continuously, the block SHALL accept a new operation on every IDLE edge, giving back-to-back operations every WIDTH/2+2 edges.
REQ-025 Borrow SHALL propagate across all digits. A result that wraps past 0 SHALL produce Bout=1 and diff = the mod-2^WIDTH value.

Reset
REQ-026 When rst_n=0, the block SHALL immediately, without waiting for clk: set the state to IDLE; set diff=0, Bout=0, busy=0 and done=0; clear the counter, the borrow register, the operand registers and the result register.
REQ-027 A reset asserted during RUN or DONE SHALL abort the operation. No done pulse SHALL be produced for the aborted operation.
REQ-028 After rst_n returns high, the first rising edge SHALL behave as an IDLE edge: it accepts start if start=1.

Verification (WIDTH=8)
REQ-029 The bench SHALL cover: A=0x35, B=0x12, Bin=0, start for 1 cycle -> busy high for 4 cycles, then done=1 for 1 cycle with diff=0x23, Bout=0.
REQ-030 The bench SHALL cover: A=0x00, B=0x01, Bin=0 -> diff=0xFF, Bout=1.
REQ-031 The bench SHALL cover: A=0x80, B=0x7F, Bin=1 -> diff=0x00, Bout=0. A=0x00, B=0xFF, Bin=1 -> diff=0x00, Bout=1.
REQ-032 The bench SHALL cover: accept A=0x10, B=0x01, then during RUN pulse start with A=0xFF, B=0x00 and change A and B -> a single done with diff=0x0F, Bout=0; the second request is ignored.
REQ-033 The bench SHALL cover: start held high with constant A=0x05, B=0x03 -> done pulses every 6 cycles, each with diff=0x02, Bout=0.
REQ-034 The bench SHALL cover: rst_n low on the 2nd RUN cycle -> diff, Bout, busy and done go to 0 immediately, and no done follows; after release, A=0x09, B=0x04 -> diff=0x05.
